twofish_key_sched_ctrl: RTL

// Sequences the combinational Twofish subkey generator (h-function/PHT pair stage)

---
 rtl/twofish_key_sched_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/twofish_key_sched_ctrl.sv
// -----------------------------------------------------------------------------
// twofish_key_sched_ctrl
//
// Purpose:
//   Drives the external combinational Twofish subkey pair generator
//   (h-function + PHT) over pair index a = 0..NUM_PAIRS-1. This expands one
//   128-bit key into 2*NUM_PAIRS 32-bit round subkeys. The results go into an
//   internal subkey register file. The round datapath reads that file through
//   an indexed port with a registered output.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   i_start       pulse: latch i_key_in and begin expansion (only when o_ready)
//   i_key_in      user key {M0,M1,M2,M3}
//   o_ready       1 in IDLE or DONE: a new start is accepted
//   o_busy        1 while expanding (RUN)
//   o_done        one-cycle registered pulse after the final pair write
//   o_keys_valid  1 when the file holds the full schedule of the last key
//   o_h_key       latched key, feeds the pair generator
//   o_h_a         current pair index, feeds the pair generator
//   i_h_k_even    generator output K[2a]
//   i_h_k_odd     generator output K[2a+1] (already rotated left by 9)
//   i_rd_idx      subkey read index 0..2*NUM_PAIRS-1
//   o_rd_key      registered subkey K[i_rd_idx] (0 when the index is out of range)
// -----------------------------------------------------------------------------
module twofish_key_sched_ctrl #(
    parameter int NUM_PAIRS = 20,
    parameter int IDX_W     = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [127:0]       i_key_in,
    output logic               o_ready,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_keys_valid,
    output logic [127:0]       o_h_key,
    output logic [IDX_W-1:0]   o_h_a,
    input  logic [31:0]        i_h_k_even,
    input  logic [31:0]        i_h_k_odd,
    input  logic [IDX_W-1:0]   i_rd_idx,
    output logic [31:0]        o_rd_key
);

    localparam int               NUM_KEYS    = 2 * NUM_PAIRS;
    localparam logic [IDX_W-1:0] LP_LAST_A   = IDX_W'(NUM_PAIRS - 1);
    localparam logic [IDX_W-1:0] LP_NUM_KEYS = IDX_W'(NUM_KEYS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_ready;
    logic               w_busy;
    logic               w_accept;
    logic               w_last;

    logic [127:0]       r_key;
    logic [IDX_W-1:0]   r_a;
    logic               r_done;
    logic               r_keys_valid;
    logic [31:0]        r_rd_key;

    logic [31:0]        w_file [NUM_KEYS];
    logic [31:0]        w_rd_word;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_busy       = 1'b0;
        w_accept     = 1'b0;
        w_last       = (r_a == LP_LAST_A);
        unique case (r_state)
            ST_IDLE: begin
                w_ready  = 1'b1;
                w_accept = i_start;
                if (i_start) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_ready  = 1'b1;
                w_accept = i_start;
                if (i_start) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Key latch, pair index, status flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key        <= '0;
            r_a          <= '0;
            r_done       <= 1'b0;
            r_keys_valid <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_key        <= i_key_in;
                r_a          <= '0;
                r_keys_valid <= 1'b0;
            end else if (w_busy) begin
                if (w_last) begin
                    // The index stays on the last pair so o_h_a does not wrap in DONE.
                    r_done       <= 1'b1;
                    r_keys_valid <= 1'b1;
                end else begin
                    r_a <= r_a + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Subkey file: each RUN cycle writes entry 2a (even) and 2a+1 (odd).
    // The generator is combinational from o_h_key/o_h_a. Both are registers,
    // so its outputs settle within the same cycle and are captured directly.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : gen_file
            logic [31:0] r_entry;
            logic        w_we;
            logic [31:0] w_wdata;

            assign w_we = w_busy && (r_a == IDX_W'(gi / 2));

            if ((gi % 2) == 0) begin : gen_even
                assign w_wdata = i_h_k_even;
            end else begin : gen_odd
                assign w_wdata = i_h_k_odd;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_entry <= '0;
                end else if (w_we) begin
                    r_entry <= w_wdata;
                end
            end

            assign w_file[gi] = r_entry;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read port: one-cycle latency with no write bypass. A read of an entry
    // written on the same edge returns the previous contents.
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_word = '0;
        if (i_rd_idx < LP_NUM_KEYS) begin
            w_rd_word = w_file[i_rd_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_key <= '0;
        end else begin
            r_rd_key <= w_rd_word;
        end
    end

    assign o_ready      = w_ready;
    assign o_busy       = w_busy;
    assign o_done       = r_done;
    assign o_keys_valid = r_keys_valid;
    assign o_h_key      = r_key;
    assign o_h_a        = r_a;
    assign o_rd_key     = r_rd_key;

endmodule
